// File: rtl/capture_window_ctrl_if.sv
// Video timing, target request and capture-window signals shared by
// capture_window_ctrl (slave) and its stimulus/consumer side (master).
interface capture_window_ctrl_if;
    logic        i_hsync;
    logic        i_vsync;
    logic        i_de;
    logic        i_tgt_valid;
    logic [11:0] i_tgt_x;
    logic [11:0] i_tgt_y;
    logic [11:0] i_win_w;
    logic [11:0] i_win_h;
    logic        i_freeze;
    logic [11:0] hcount;
    logic [11:0] vcount;
    logic [11:0] hcount_l;
    logic [11:0] hcount_r;
    logic [11:0] vcount_l;
    logic [11:0] vcount_r;
    logic        o_locked;
    logic [1:0]  o_state;

    modport master (
        output i_hsync, i_vsync, i_de, i_tgt_valid, i_tgt_x, i_tgt_y,
               i_win_w, i_win_h, i_freeze,
        input  hcount, vcount, hcount_l, hcount_r, vcount_l, vcount_r,
               o_locked, o_state
    );

    modport slave (
        input  i_hsync, i_vsync, i_de, i_tgt_valid, i_tgt_x, i_tgt_y,
               i_win_w, i_win_h, i_freeze,
        output hcount, vcount, hcount_l, hcount_r, vcount_l, vcount_r,
               o_locked, o_state
    );
endinterface

// File: rtl/capture_window_ctrl.sv
// Pixel/line counters plus a tracking FSM that sets exclusive capture-window bounds.
// Bounds and state update one cycle after a vsync rise; no backpressure on inputs.
module capture_window_ctrl #(
    parameter int H_ACTIVE    = 1280,
    parameter int V_ACTIVE    = 720,
    parameter int LOST_FRAMES = 8
) (
    input  logic pixelclk,
    input  logic reset_n,
    capture_window_ctrl_if.slave vid
);
    typedef enum logic [1:0] {IDLE = 2'b00, TRACK = 2'b01, HOLD = 2'b10} state_t;

    localparam logic [12:0] H_MAX  = 13'(H_ACTIVE);
    localparam logic [12:0] V_MAX  = 13'(V_ACTIVE);
    localparam logic [11:0] H_LAST = 12'(H_ACTIVE - 1);
    localparam logic [11:0] V_LAST = 12'(V_ACTIVE - 1);
    localparam logic [3:0]  LOST   = 4'(LOST_FRAMES);

    logic        de_d, vsync_d, fb, pending;
    logic [11:0] hcnt, vcnt;
    logic [11:0] sx, sy, sw, sh;
    logic [11:0] hl, hr, vl, vr;
    logic [3:0]  miss, miss_n;
    logic        locked;
    state_t      state, state_n;
    logic        load_win, load_full;
    logic        vsync_rise;
    logic        unused_hsync;

    assign unused_hsync = vid.i_hsync;
    assign vsync_rise   = vid.i_vsync & ~vsync_d;

    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            de_d    <= 1'b0;
            vsync_d <= 1'b0;
            fb      <= 1'b0;
            hcnt    <= '0;
            vcnt    <= '0;
        end else begin
            de_d    <= vid.i_de;
            vsync_d <= vid.i_vsync;
            fb      <= vsync_rise;
            if (!vid.i_de)
                hcnt <= '0;
            else if (hcnt != 12'hFFF)
                hcnt <= hcnt + 12'd1;
            // Frame clear takes priority over a coincident end-of-line increment.
            if (vsync_rise)
                vcnt <= '0;
            else if (de_d && !vid.i_de && vcnt != 12'hFFF)
                vcnt <= vcnt + 12'd1;
        end
    end

    // A strobe landing in the FB cycle survives the clear and applies next frame.
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= 1'b0;
            sx <= '0;
            sy <= '0;
            sw <= '0;
            sh <= '0;
        end else if (vid.i_tgt_valid) begin
            pending <= 1'b1;
            sx <= vid.i_tgt_x;
            sy <= vid.i_tgt_y;
            sw <= vid.i_win_w;
            sh <= vid.i_win_h;
        end else if (fb) begin
            pending <= 1'b0;
        end
    end

    logic [12:0] cx, cy, half_w, half_h, sum_x, sum_y;
    logic [11:0] eff_w, eff_h;
    logic [11:0] nhl, nhr, nvl, nvr;

    always_comb begin
        cx     = {1'b0, (sx > H_LAST) ? H_LAST : sx};
        cy     = {1'b0, (sy > V_LAST) ? V_LAST : sy};
        eff_w  = (sw == '0) ? 12'd200 : sw;
        eff_h  = (sh == '0) ? 12'd200 : sh;
        half_w = {2'b00, eff_w[11:1]};
        half_h = {2'b00, eff_h[11:1]};
        sum_x  = cx + half_w + 13'd1;
        sum_y  = cy + half_h + 13'd1;
        nhl    = (cx > half_w) ? 12'(cx - half_w - 13'd1) : 12'd0;
        nvl    = (cy > half_h) ? 12'(cy - half_h - 13'd1) : 12'd0;
        nhr    = (sum_x > H_MAX) ? H_MAX[11:0] : sum_x[11:0];
        nvr    = (sum_y > V_MAX) ? V_MAX[11:0] : sum_y[11:0];
    end

    always_comb begin
        state_n   = state;
        miss_n    = miss;
        load_win  = 1'b0;
        load_full = 1'b0;
        if (fb && !vid.i_freeze) begin
            case (state)
                IDLE: if (pending) begin
                    load_win = 1'b1;
                    state_n  = TRACK;
                end
                TRACK: if (pending) begin
                    load_win = 1'b1;
                    miss_n   = '0;
                end else begin
                    miss_n  = 4'd1;
                    state_n = HOLD;
                end
                HOLD: if (pending) begin
                    load_win = 1'b1;
                    miss_n   = '0;
                    state_n  = TRACK;
                end else if (miss + 4'd1 >= LOST) begin
                    load_full = 1'b1;
                    miss_n    = '0;
                    state_n   = IDLE;
                end else begin
                    miss_n = miss + 4'd1;
                end
                default: begin
                    load_full = 1'b1;
                    miss_n    = '0;
                    state_n   = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            miss   <= '0;
            locked <= 1'b0;
            hl     <= '0;
            hr     <= H_MAX[11:0];
            vl     <= '0;
            vr     <= V_MAX[11:0];
        end else begin
            state  <= state_n;
            miss   <= miss_n;
            locked <= (state_n == TRACK);
            if (load_win) begin
                hl <= nhl;
                hr <= nhr;
                vl <= nvl;
                vr <= nvr;
            end else if (load_full) begin
                hl <= '0;
                hr <= H_MAX[11:0];
                vl <= '0;
                vr <= V_MAX[11:0];
            end
        end
    end

    assign vid.hcount   = hcnt;
    assign vid.vcount   = vcnt;
    assign vid.hcount_l = hl;
    assign vid.hcount_r = hr;
    assign vid.vcount_l = vl;
    assign vid.vcount_r = vr;
    assign vid.o_locked = locked;
    assign vid.o_state  = state;
endmodule

// File: tb/tb_capture_window_ctrl.sv
// Directed bench: expected window/state pushed per frame, popped and checked at each frame boundary.
module tb_capture_window_ctrl;
    logic pixelclk = 1'b0;
    logic reset_n  = 1'b0;

    capture_window_ctrl_if vif ();

    capture_window_ctrl #(.H_ACTIVE(1280), .V_ACTIVE(720), .LOST_FRAMES(8)) dut (
        .pixelclk (pixelclk),
        .reset_n  (reset_n),
        .vid      (vif)
    );

    always #5 pixelclk = ~pixelclk;

    typedef struct {
        int hl; int hr; int vl; int vr; int st; int lk;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    exp_t full_win;
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input int expv);
        tests++;
        assert (obs === 32'(expv)) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge pixelclk);
        #1;
    endtask

    task automatic line(input int n);
        vif.i_de = 1'b1;
        repeat (n) tick();
        vif.i_de = 1'b0;
        repeat (2) tick();
    endtask

    task automatic strobe(input int x, input int y, input int w, input int h);
        vif.i_tgt_x = 12'(x);
        vif.i_tgt_y = 12'(y);
        vif.i_win_w = 12'(w);
        vif.i_win_h = 12'(h);
        vif.i_tgt_valid = 1'b1;
        tick();
        vif.i_tgt_valid = 1'b0;
        tick();
    endtask

    // Reference window: visible span centre +/- half, bounds one outside, clipped to the frame.
    function automatic exp_t win(input int x, input int y, input int w, input int h);
        exp_t e;
        int cx, cy, hw, hh;
        cx = (x > 1279) ? 1279 : x;
        cy = (y > 719) ? 719 : y;
        hw = ((w == 0) ? 200 : w) / 2;
        hh = ((h == 0) ? 200 : h) / 2;
        e.hl = (cx - hw - 1 < 0) ? 0 : cx - hw - 1;
        e.hr = (cx + hw + 1 > 1280) ? 1280 : cx + hw + 1;
        e.vl = (cy - hh - 1 < 0) ? 0 : cy - hh - 1;
        e.vr = (cy + hh + 1 > 720) ? 720 : cy + hh + 1;
        e.st = 1;
        e.lk = 1;
        return e;
    endfunction

    task automatic check_win(input string tag, input exp_t e);
        chk({tag, "_hl"}, 32'(vif.hcount_l), e.hl);
        chk({tag, "_hr"}, 32'(vif.hcount_r), e.hr);
        chk({tag, "_vl"}, 32'(vif.vcount_l), e.vl);
        chk({tag, "_vr"}, 32'(vif.vcount_r), e.vr);
        chk({tag, "_st"}, 32'(vif.o_state), e.st);
        chk({tag, "_lk"}, 32'(vif.o_locked), e.lk);
    endtask

    task automatic frame_end(input string tag);
        exp_t e;
        vif.i_vsync = 1'b1;
        tick();
        tick();
        vif.i_vsync = 1'b0;
        tick();
        tick();
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s: observed empty scoreboard expected one entry", tag);
        end else begin
            e = sb.pop_front();
            check_win(tag, e);
        end
    endtask

    initial begin
        full_win = '{0, 1280, 0, 720, 0, 0};
        vif.i_hsync = 1'b0;
        vif.i_vsync = 1'b0;
        vif.i_de = 1'b0;
        vif.i_tgt_valid = 1'b0;
        vif.i_tgt_x = '0;
        vif.i_tgt_y = '0;
        vif.i_win_w = '0;
        vif.i_win_h = '0;
        vif.i_freeze = 1'b0;

        repeat (3) tick();
        chk("rst_hcount", 32'(vif.hcount), 0);
        chk("rst_vcount", 32'(vif.vcount), 0);
        check_win("rst", full_win);
        reset_n = 1'b1;
        tick();

        // Full-frame idle frame: one full-width line, then enough short lines to reach line 719.
        sb.push_back(full_win);
        frame_end("fb_start");
        vif.i_de = 1'b1;
        for (int i = 0; i < 1280; i++) begin
            chk("hcount_run", 32'(vif.hcount), i);
            tick();
        end
        vif.i_de = 1'b0;
        tick();
        tick();
        chk("vcount_line1", 32'(vif.vcount), 1);
        repeat (718) line(1);
        vif.i_de = 1'b1;
        chk("vcount_last", 32'(vif.vcount), 719);
        tick();
        vif.i_de = 1'b0;
        tick();
        sb.push_back(full_win);
        frame_end("fb_idle");

        // Acquire centre target; window must not move until the boundary.
        line(4);
        strobe(640, 360, 100, 100);
        chk("pre_fb_hl", 32'(vif.hcount_l), 0);
        chk("pre_fb_hr", 32'(vif.hcount_r), 1280);
        cur = win(640, 360, 100, 100);
        sb.push_back(cur);
        frame_end("fb_lock");

        line(3);
        strobe(10, 5, 100, 100);
        cur = win(10, 5, 100, 100);
        sb.push_back(cur);
        frame_end("fb_edge_low");

        strobe(1279, 900, 100, 100);
        cur = win(1279, 900, 100, 100);
        sb.push_back(cur);
        frame_end("fb_edge_high");

        strobe(10, 10, 30, 30);
        line(2);
        strobe(640, 360, 0, 0);
        cur = win(640, 360, 0, 0);
        sb.push_back(cur);
        frame_end("fb_default_size");

        // Target loss: seven held frames, then revert on the eighth.
        for (int f = 1; f <= 8; f++) begin
            line(2);
            if (f < 8) sb.push_back('{cur.hl, cur.hr, cur.vl, cur.vr, 2, 0});
            else       sb.push_back(full_win);
            frame_end($sformatf("fb_lost%0d", f));
        end

        strobe(640, 360, 100, 100);
        cur = win(640, 360, 100, 100);
        sb.push_back(cur);
        frame_end("fb_relock");
        for (int f = 1; f <= 4; f++) begin
            line(2);
            sb.push_back('{cur.hl, cur.hr, cur.vl, cur.vr, 2, 0});
            frame_end($sformatf("fb_hold%0d", f));
        end
        strobe(300, 200, 50, 60);
        cur = win(300, 200, 50, 60);
        sb.push_back(cur);
        frame_end("fb_reacquire");

        // Frozen boundaries ignore fresh strobes.
        vif.i_freeze = 1'b1;
        for (int f = 0; f < 3; f++) begin
            strobe(500 + 10 * f, 400, 40, 40);
            sb.push_back(cur);
            frame_end($sformatf("fb_frozen%0d", f));
        end
        vif.i_freeze = 1'b0;
        strobe(100, 100, 20, 20);
        cur = win(100, 100, 20, 20);
        sb.push_back(cur);
        frame_end("fb_unfreeze");

        // Vsync rising in the same cycle as a line end clears vcount.
        line(3);
        line(3);
        strobe(100, 100, 20, 20);
        vif.i_de = 1'b1;
        repeat (3) tick();
        vif.i_de = 1'b0;
        vif.i_vsync = 1'b1;
        tick();
        chk("vsync_de_fall_vcount", 32'(vif.vcount), 0);
        tick();
        vif.i_vsync = 1'b0;
        tick();
        tick();
        check_win("fb_coincident", cur);

        // Asynchronous reset mid-line while tracking.
        line(3);
        vif.i_de = 1'b1;
        repeat (5) tick();
        chk("pre_rst_state", 32'(vif.o_state), 1);
        reset_n = 1'b0;
        #2;
        chk("arst_hcount", 32'(vif.hcount), 0);
        chk("arst_vcount", 32'(vif.vcount), 0);
        check_win("arst", full_win);
        vif.i_de = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/capture_window_ctrl.md
Name: capture_window_ctrl

Overview:
- Generates the active-pixel coordinates (hcount, vcount) and the capture window bounds consumed by the single-window capture stage.
- Window bounds are built from a target centre (x, y) and a window size supplied by the detection logic.
- Bounds change only at frame boundaries, so a frame is never torn.
- A small tracking FSM holds the window through brief target loss, then falls back to full-frame pass-through.

Parameters:
- H_ACTIVE, 1280: active pixels per line.
- V_ACTIVE, 720: active lines per frame.
- LOST_FRAMES, 8: consecutive frames without a target before the window reverts to full frame (1..15).

Ports:
- pixelclk  input  1  pixel clock; all logic is on its rising edge.
- reset_n  input  1  asynchronous active-low reset.
- i_hsync  input  1  horizontal sync; unused internally, kept for interface uniformity.
- i_vsync  input  1  vertical sync, active high.
- i_de  input  1  data enable, high during active pixels.
- i_tgt_valid  input  1  one-cycle strobe; i_tgt_x/i_tgt_y are valid in that cycle.
- i_tgt_x  input  12  target centre column.
- i_tgt_y  input  12  target centre row.
- i_win_w  input  12  window width; 0 selects 200.
- i_win_h  input  12  window height; 0 selects 200.
- i_freeze  input  1  level; while high, bounds and FSM hold.
- hcount  output  12  pixel column of the current i_de cycle.
- vcount  output  12  active line index.
- hcount_l  output  12  exclusive left bound.
- hcount_r  output  12  exclusive right bound.
- vcount_l  output  12  exclusive top bound.
- vcount_r  output  12  exclusive bottom bound.
- o_locked  output  1  high in TRACK.
- o_state  output  2  00 IDLE, 01 TRACK, 10 HOLD.

Behaviour:
- Reset (async, reset_n=0):
  - hcount=0, vcount=0.
  - Full-frame bounds: hcount_l=0, hcount_r=H_ACTIVE, vcount_l=0, vcount_r=V_ACTIVE.
  - state=IDLE, o_locked=0, miss_cnt=0, pending flag=0.
  - Reset asserted mid-frame takes effect immediately; after release the next vsync rise starts a clean frame.
- hcount:
  - Registered; i_de=1 gives hcount+1, i_de=0 gives 0.
  - Pixel n of a line is therefore present on i_de while hcount=n.
  - Saturates at 4095.
- vcount:
  - Increments on each i_de falling edge (registered i_de_d=1, i_de=0).
  - Cleared on an i_vsync rising edge. Clear wins if both occur in the same cycle.
  - Saturates at 4095.
- Frame boundary (FB): the cycle after an i_vsync rising edge is detected. All bound and FSM updates happen only at FB.
- Target capture:
  - i_tgt_valid latches x, y, win_w, win_h into shadow registers and sets pending=1.
  - A later strobe in the same frame overwrites the shadow.
  - pending clears at FB. A strobe in the FB cycle itself counts for the next frame.
- Bound arithmetic (13-bit intermediates), with hw=w>>1 and hh=h>>1:
  - hcount_l = (x > hw) ? x-hw-1 : 0
  - hcount_r = (x+hw+1 > H_ACTIVE) ? H_ACTIVE : x+hw+1
  - vcount_l and vcount_r use the same form with y, hh and V_ACTIVE.
  - x >= H_ACTIVE is clamped to H_ACTIVE-1 before use; y likewise to V_ACTIVE-1.
  - Bounds are exclusive. Visible columns are x-hw..x+hw, clipped to the frame.
- FSM at FB (i_freeze=1 at FB means no transition, no bound change, miss_cnt unchanged):
  - IDLE:
    - pending=1: load bounds, go to TRACK.
    - pending=0: stay in IDLE with full-frame bounds.
  - TRACK:
    - pending=1: reload bounds, miss_cnt=0.
    - pending=0: miss_cnt=1, go to HOLD; bounds unchanged.
  - HOLD:
    - pending=1: reload bounds, miss_cnt=0, go to TRACK.
    - pending=0: miss_cnt+1. When the incremented value equals LOST_FRAMES, go to IDLE, load full-frame bounds, miss_cnt=0.
- Outputs:
  - o_locked and o_state are registered and change only at FB or reset.
  - Bound outputs are registered and stable for the whole frame.

Test Plan:
- Reset, then one frame with no target -> bounds 0/1280/0/720, o_state=00, hcount runs 0..1279 during each i_de burst, vcount reaches 719 before vsync.
- Strobe x=640, y=360, w=h=100 mid-frame -> bounds unchanged until next FB; then hcount_l=589, hcount_r=691, vcount_l=309, vcount_r=411, o_locked=1.
- Edge target x=10, y=5, w=h=100 -> hcount_l=0, hcount_r=61, vcount_l=0, vcount_r=56; x=1279 gives hcount_r=1280.
- Lock, then 7 frames with no strobe -> state HOLD and bounds held through all 7; 8th FB -> IDLE with full-frame bounds. A strobe in frame 5 instead returns to TRACK with new bounds.
- i_freeze=1 across 3 FBs with strobes present -> bounds and state unchanged; after i_freeze=0, the next FB loads the latest strobe.
- Assert reset_n=0 mid-line while in TRACK -> all outputs go to reset values in the same cycle without waiting for a clock edge. An i_vsync rise coinciding with an i_de fall -> vcount=0.
